udp_tx: RTL and testbench
=========================

UDP_TX -- requirements
Module: udp_tx

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  P_ST_TARGET_PORT, 16'd8080, destination port after reset.
  P_ST_SOURCE_PORT, 16'd8080, source port after reset.
  P_MAX_LEN, 1024, maximum payload bytes per frame.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports, one per line (name, direction, width, meaning):
  i_clk  in  1  clock.
  i_rst_n  in  1  async active-low reset.
  i_target_port  in  16  destination port.
  i_target_valid  in  1  load i_target_port.
  i_source_port  in  16  source port.
  i_source_valid  in  1  load i_source_port.
  i_udp_data  in  8  payload byte.
  i_udp_len  in  16  declared payload length, sampled on first beat.
  i_udp_last  in  1  final payload byte.
  i_udp_valid  in  1  byte valid.
  o_udp_ready  out  1  block accepts payload.
  o_ip_data  out  8  UDP datagram byte to IP layer.
  o_ip_len  out  16  UDP datagram length (header + payload).
  o_ip_type  out  8  IP protocol number.
  o_ip_last  out  1  final datagram byte.
  o_ip_valid  out  1  datagram byte valid.
  o_len_err  out  1  one-cycle length-error pulse.

Function
REQ-004 A beat SHALL be accepted only when i_udp_valid and o_udp_ready are both 1; i_udp_valid is ignored otherwise.
REQ-005 Port registers: a port SHALL load on its valid strobe at any time; the block SHALL snapshot both ports at entry to HEAD, so mid-frame changes apply to the next frame.
REQ-006 States: IDLE, RECV, HEAD, DATA.
  - IDLE -> RECV on the first accepted beat without last.
  - IDLE -> HEAD on the first accepted beat with last.
  - RECV -> HEAD on an accepted beat with last.
  - HEAD -> DATA after 8 header bytes.
  - DATA -> IDLE after the final payload byte.
REQ-007 o_udp_ready SHALL be 1 in IDLE and RECV, and 0 in HEAD and DATA, and 0 in the cycle after the last beat is accepted.
REQ-008 Store-and-forward: payload bytes SHALL be written into an internal P_MAX_LEN x 8 buffer; a byte counter C counts stored bytes.
REQ-009 Emission SHALL start only after the whole frame has been received.
  - Last beat accepted in cycle N -> o_ip_valid = 1 from cycle N+2.
  - o_ip_valid stays 1 for exactly C+8 contiguous cycles.
  - o_ip_last = 1 only on the final byte.
REQ-010 Byte order on o_ip_data:
  - Bytes 0-1: source port, MSB first.
  - Bytes 2-3: target port, MSB first.
  - Bytes 4-5: length C+8, MSB first.
  - Bytes 6-7: checksum 16'h0000.
  - Then payload bytes in arrival order.
REQ-011 o_ip_len = C+8 and o_ip_type = 8'd17 SHALL be stable for every cycle o_ip_valid = 1.
REQ-012 Length arithmetic SHALL be 16-bit; C is never greater than P_MAX_LEN, so there is no overflow.
REQ-013 Declared-length mismatch: if C != i_udp_len at last, o_len_err SHALL pulse in cycle N+1. The frame is still emitted using C.
REQ-014 Overflow: accepted bytes beyond P_MAX_LEN SHALL be discarded.
  - C saturates at P_MAX_LEN.
  - o_len_err pulses once, on the first discarded byte.
  - The frame is emitted truncated when last arrives.
REQ-015 A last beat with C = 0 (single-byte frame) SHALL be legal and produce a 9-byte datagram.
REQ-016 There is no downstream backpressure; the IP layer SHALL be assumed always ready.

Reset
REQ-017 On reset assertion:
  - Outputs: o_ip_data = 0, o_ip_len = 0, o_ip_type = 0, o_ip_last = 0, o_ip_valid = 0, o_len_err = 0, o_udp_ready = 0.
  - Internal: state = IDLE, C = 0.
  - Port registers load P_ST_TARGET_PORT and P_ST_SOURCE_PORT.
REQ-018 After reset release, o_udp_ready SHALL rise in the first clock.
REQ-019 Reset mid-frame SHALL abort immediately with no partial last; buffer contents are don't-care.

Verification
REQ-020 4-byte payload AA BB CC DD, len = 4, default ports -> 12 bytes:
  1F 90 1F 90 00 0C 00 00 AA BB CC DD; last on DD; o_ip_len = 12; o_ip_type = 17; valid from N+2.
REQ-021 Single byte 55, len = 1 -> 9-byte datagram, length field 00 09, last on 55.
REQ-022 Declare len = 10, send 6 bytes -> o_len_err pulse at N+1; length field 00 0E; 14 bytes emitted.
REQ-023 Send 1030 bytes -> o_len_err pulses once at byte 1025; 1032 bytes emitted; length field 04 08.
REQ-024 Pulse i_target_valid with 16'h1234 during DATA of frame 1 -> frame 1 keeps 1F 90; frame 2 bytes 2-3 = 12 34; i_udp_valid held during HEAD/DATA is not accepted.
REQ-025 Assert reset during DATA of a 100-byte frame -> all outputs 0 next edge; after release, a 4-byte frame emits correctly.

Source files
------------

// File: rtl/udp_tx.sv
// udp_tx: store-and-forward UDP transmitter.
//
// A payload frame arrives one byte per beat on i_udp_*. It is stored in an
// internal buffer. After the last byte has arrived, the block emits an 8-byte
// UDP header followed by the stored payload on o_ip_*. The IP layer is assumed
// to be always ready.
//
// Ports:
//   i_clk, i_rst_n                     clock, asynchronous active-low reset
//   i_target_port / i_target_valid     destination port register load
//   i_source_port / i_source_valid     source port register load
//   i_udp_data/len/last/valid          payload input (len sampled on first beat)
//   o_udp_ready                        payload accept (IDLE/RECV only)
//   o_ip_data/len/type/last/valid      datagram output stream
//   o_len_err                          one-cycle pulse: declared length mismatch
//                                      or first byte dropped on buffer overflow
module udp_tx #(
    parameter logic [15:0] P_ST_TARGET_PORT = 16'd8080,
    parameter logic [15:0] P_ST_SOURCE_PORT = 16'd8080,
    parameter int          P_MAX_LEN        = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_target_port,
    input  logic        i_target_valid,
    input  logic [15:0] i_source_port,
    input  logic        i_source_valid,
    input  logic [7:0]  i_udp_data,
    input  logic [15:0] i_udp_len,
    input  logic        i_udp_last,
    input  logic        i_udp_valid,
    output logic        o_udp_ready,
    output logic [7:0]  o_ip_data,
    output logic [15:0] o_ip_len,
    output logic [7:0]  o_ip_type,
    output logic        o_ip_last,
    output logic        o_ip_valid,
    output logic        o_len_err
);

    localparam int AW = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_HEAD, S_DATA} state_t;

    state_t        state_q;
    logic [15:0]   cnt_q;        // stored payload bytes (C)
    logic [15:0]   len_q;        // declared length from first beat
    logic          ovf_q;        // overflow already reported this frame
    logic [15:0]   tgt_q, src_q;
    logic [15:0]   tgt_snap_q, src_snap_q;
    logic [2:0]    hcnt_q;
    logic [AW-1:0] rd_q;
    logic          ready_q;
    logic [7:0]    data_q;
    logic [15:0]   ip_len_q;
    logic [7:0]    ip_type_q;
    logic          last_q, valid_q, len_err_q;

    logic [7:0]    mem_q [P_MAX_LEN];

    logic          accept, store, ovf_first, mismatch;
    logic [15:0]   cnt_d, decl_len, tot_len;
    logic [7:0]    hdr_byte;

    assign accept    = i_udp_valid & ready_q;
    assign store     = accept & (cnt_q < 16'(P_MAX_LEN));
    assign cnt_d     = store ? cnt_q + 16'd1 : cnt_q;
    // On the first beat len_q is not yet loaded, so compare against the input.
    assign decl_len  = (state_q == S_IDLE) ? i_udp_len : len_q;
    assign ovf_first = accept & ~store & ~ovf_q;
    assign mismatch  = accept & i_udp_last & (cnt_d != decl_len);
    assign tot_len   = cnt_q + 16'd8;

    always_comb begin
        hdr_byte = 8'h00;
        case (hcnt_q)
            3'd0:    hdr_byte = src_snap_q[15:8];
            3'd1:    hdr_byte = src_snap_q[7:0];
            3'd2:    hdr_byte = tgt_snap_q[15:8];
            3'd3:    hdr_byte = tgt_snap_q[7:0];
            3'd4:    hdr_byte = tot_len[15:8];
            3'd5:    hdr_byte = tot_len[7:0];
            default: hdr_byte = 8'h00;   // checksum not computed
        endcase
    end

    // Port registers load at any time; the FSM snapshots them on HEAD entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tgt_q <= P_ST_TARGET_PORT;
            src_q <= P_ST_SOURCE_PORT;
        end else begin
            if (i_target_valid) tgt_q <= i_target_port;
            if (i_source_valid) src_q <= i_source_port;
        end
    end

    // Payload buffer; contents are don't-care after reset.
    always_ff @(posedge i_clk) begin
        if (store) mem_q[cnt_q[AW-1:0]] <= i_udp_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            ovf_q      <= 1'b0;
            tgt_snap_q <= '0;
            src_snap_q <= '0;
            hcnt_q     <= '0;
            rd_q       <= '0;
            ready_q    <= 1'b0;
            data_q     <= '0;
            ip_len_q   <= '0;
            ip_type_q  <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            len_err_q <= mismatch | ovf_first;
            case (state_q)
                S_IDLE, S_RECV: begin
                    ready_q   <= 1'b1;
                    valid_q   <= 1'b0;
                    last_q    <= 1'b0;
                    data_q    <= '0;
                    ip_len_q  <= '0;
                    ip_type_q <= '0;
                    if (accept) begin
                        cnt_q <= cnt_d;
                        if (!store) ovf_q <= 1'b1;
                        if (state_q == S_IDLE) len_q <= i_udp_len;
                        if (i_udp_last) begin
                            state_q    <= S_HEAD;
                            ready_q    <= 1'b0;
                            hcnt_q     <= '0;
                            tgt_snap_q <= tgt_q;
                            src_snap_q <= src_q;
                        end else begin
                            state_q <= S_RECV;
                        end
                    end
                end
                S_HEAD: begin
                    valid_q   <= 1'b1;
                    last_q    <= 1'b0;
                    data_q    <= hdr_byte;
                    ip_len_q  <= tot_len;
                    ip_type_q <= 8'd17;
                    hcnt_q    <= hcnt_q + 3'd1;
                    if (hcnt_q == 3'd7) begin
                        state_q <= S_DATA;
                        rd_q    <= '0;
                    end
                end
                S_DATA: begin
                    valid_q   <= 1'b1;
                    data_q    <= mem_q[rd_q];
                    ip_len_q  <= tot_len;
                    ip_type_q <= 8'd17;
                    rd_q      <= rd_q + 1'b1;
                    last_q    <= 1'b0;
                    if (16'(rd_q) == cnt_q - 16'd1) begin
                        last_q  <= 1'b1;
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_udp_ready = ready_q;
    assign o_ip_data   = data_q;
    assign o_ip_len    = ip_len_q;
    assign o_ip_type   = ip_type_q;
    assign o_ip_last   = last_q;
    assign o_ip_valid  = valid_q;
    assign o_len_err   = len_err_q;

endmodule

// File: tb/tb_udp_tx.sv
// Directed testbench for udp_tx.
module tb_udp_tx;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [15:0] i_target_port = '0;
    logic        i_target_valid = 1'b0;
    logic [15:0] i_source_port = '0;
    logic        i_source_valid = 1'b0;
    logic [7:0]  i_udp_data = '0;
    logic [15:0] i_udp_len = '0;
    logic        i_udp_last = 1'b0;
    logic        i_udp_valid = 1'b0;
    logic        o_udp_ready;
    logic [7:0]  o_ip_data;
    logic [15:0] o_ip_len;
    logic [7:0]  o_ip_type;
    logic        o_ip_last;
    logic        o_ip_valid;
    logic        o_len_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] pl [0:1103];

    udp_tx dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_target_port  (i_target_port),
        .i_target_valid (i_target_valid),
        .i_source_port  (i_source_port),
        .i_source_valid (i_source_valid),
        .i_udp_data     (i_udp_data),
        .i_udp_len      (i_udp_len),
        .i_udp_last     (i_udp_last),
        .i_udp_valid    (i_udp_valid),
        .o_udp_ready    (o_udp_ready),
        .o_ip_data      (o_ip_data),
        .o_ip_len       (o_ip_len),
        .o_ip_type      (o_ip_type),
        .o_ip_last      (o_ip_last),
        .o_ip_valid     (o_ip_valid),
        .o_len_err      (o_len_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int n, input int seed);
        for (int i = 0; i < n; i++) pl[i] = 8'((i * 13 + seed) & 8'hFF);
    endtask

    // Drive n beats back-to-back; err_at is the 1-based beat whose edge
    // should raise o_len_err (0 = no pulse expected).
    task automatic send(input int n, input logic [15:0] dlen, input int err_at);
        int pulses = 0;
        int at = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            i_udp_valid = 1'b1;
            i_udp_data  = pl[i];
            i_udp_len   = dlen;
            i_udp_last  = (i == n - 1);
            @(posedge i_clk);
            #1;
            if (o_len_err) begin
                pulses++;
                at = i + 1;
            end
            if (o_ip_valid) begin
                pulses += 1000;   // output must stay quiet while receiving
            end
        end
        i_udp_valid = 1'b0;
        i_udp_last  = 1'b0;
        chk("len_err_pulses", pulses, (err_at != 0) ? 1 : 0);
        chk("len_err_beat", at, err_at);
        chk("ready_after_last", o_udp_ready, 1'b0);
    endtask

    // Check the emitted datagram of total bytes cycle by cycle from N+2.
    task automatic collect(input int total, input logic [15:0] src, input logic [15:0] tgt,
                           input bit hold, input int pulse_idx);
        logic [7:0] exp_b;
        logic [15:0] tl;
        int bad = 0;
        tl = 16'(total);
        if (hold) begin
            i_udp_valid = 1'b1;
            i_udp_last  = 1'b1;
            i_udp_data  = 8'hEE;
        end
        for (int i = 0; i < total; i++) begin
            @(posedge i_clk);
            #1;
            case (i)
                0: exp_b = src[15:8];
                1: exp_b = src[7:0];
                2: exp_b = tgt[15:8];
                3: exp_b = tgt[7:0];
                4: exp_b = tl[15:8];
                5: exp_b = tl[7:0];
                6, 7: exp_b = 8'h00;
                default: exp_b = pl[i - 8];
            endcase
            if (i < 8) begin
                chk($sformatf("hdr_byte%0d", i), o_ip_data, exp_b);
            end else if (o_ip_data !== exp_b) begin
                bad++;
                if (bad == 1) chk($sformatf("payload_byte%0d", i), o_ip_data, exp_b);
            end
            if (o_ip_valid !== 1'b1 || o_ip_last !== (i == total - 1) || o_ip_len !== tl
                || o_ip_type !== 8'd17 || o_udp_ready !== (i == total - 1) || o_len_err !== 1'b0) begin
                bad++;
                chk($sformatf("ctrl_byte%0d", i),
                    {o_ip_valid, o_ip_last, o_udp_ready, o_len_err, o_ip_type, o_ip_len},
                    {1'b1, (i == total - 1), (i == total - 1), 1'b0, 8'd17, tl});
            end
            if (i == pulse_idx) begin
                i_target_port  = 16'h1234;
                i_target_valid = 1'b1;
            end
            if (i == pulse_idx + 1) i_target_valid = 1'b0;
            if (hold && i == total - 1) begin
                i_udp_valid = 1'b0;
                i_udp_last  = 1'b0;
            end
        end
        chk("payload_errors", bad, 0);
        chk("last_on_final", o_ip_last, 1'b1);
        @(posedge i_clk);
        #1;
        chk("valid_drops", o_ip_valid, 1'b0);
        chk("ready_idle", o_udp_ready, 1'b1);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_data", o_ip_data, 8'h00);
        chk("rst_len", o_ip_len, 16'h0000);
        chk("rst_type", o_ip_type, 8'h00);
        chk("rst_last", o_ip_last, 1'b0);
        chk("rst_valid", o_ip_valid, 1'b0);
        chk("rst_len_err", o_len_err, 1'b0);
        chk("rst_ready", o_udp_ready, 1'b0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk("ready_first_clk", o_udp_ready, 1'b1);

        // AA BB CC DD, default ports -> 1F 90 1F 90 00 0C 00 00 AA BB CC DD
        pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC; pl[3] = 8'hDD;
        send(4, 16'd4, 0);
        chk("n1_valid_low", o_ip_valid, 1'b0);
        collect(12, 16'h1F90, 16'h1F90, 1'b0, -1);

        // Single-byte frame -> 9 bytes, length 00 09
        pl[0] = 8'h55;
        send(1, 16'd1, 0);
        collect(9, 16'h1F90, 16'h1F90, 1'b0, -1);

        // Declared 10, sent 6 -> error pulse at N+1, 14 bytes
        fill(6, 3);
        send(6, 16'd10, 6);
        collect(14, 16'h1F90, 16'h1F90, 1'b0, -1);

        // 1030 bytes -> truncated to 1024, error on byte 1025, length 04 08
        fill(1030, 7);
        send(1030, 16'd1024, 1025);
        collect(1032, 16'h1F90, 16'h1F90, 1'b0, -1);

        // Target port change during DATA applies to the next frame only;
        // i_udp_valid held through HEAD/DATA must be ignored.
        fill(20, 11);
        send(20, 16'd20, 0);
        collect(28, 16'h1F90, 16'h1F90, 1'b1, 12);
        fill(4, 17);
        send(4, 16'd4, 0);
        collect(12, 16'h1F90, 16'h1234, 1'b0, -1);

        // Reset during DATA of a 100-byte frame
        fill(100, 23);
        send(100, 16'd100, 0);
        repeat (20) @(posedge i_clk);
        #1;
        chk("pre_rst_valid", o_ip_valid, 1'b1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_outputs",
            {o_ip_data, o_ip_len, o_ip_type, o_ip_last, o_ip_valid, o_len_err, o_udp_ready},
            '0);
        @(posedge i_clk);
        #1;
        chk("midrst_valid_edge", o_ip_valid, 1'b0);
        chk("midrst_last_edge", o_ip_last, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk("ready_after_rerst", o_udp_ready, 1'b1);
        pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
        send(4, 16'd4, 0);
        collect(12, 16'h1F90, 16'h1F90, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
